// File: rtl/knn_pkg.sv
// Shared types and constants for the kNN query sequencer and its datapath.
//   state_t   : sequencer FSM states
//   IDX_W     : training-sample index / address width
//   LBL_W     : class label width
//   NUM_LABEL : number of label classes (2**LBL_W)
//   DIST_MAX  : all-ones distance the datapath substitutes for invalid feed slots
package knn_pkg;

  localparam int unsigned IDX_W     = 8;
  localparam int unsigned LBL_W     = 2;
  localparam int unsigned NUM_LABEL = 4;
  localparam int unsigned NUM_BIT   = 16;
  localparam int unsigned CNT_W     = 4;

  localparam logic [NUM_BIT-1:0] DIST_MAX = {NUM_BIT{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    VOTE,
    DONE
  } state_t;

endpackage

// File: rtl/knn_seq_ctrl_if.sv
// Query/feed bundle between the kNN sequencer (slave) and its host/datapath (master).
//   start, n_train      : query request and training-sample count (host -> ctrl)
//   busy, done, class_out : query status and result (ctrl -> host)
//   mem_rd_en, mem_addr : sample memory read port (ctrl -> datapath)
//   feed_valid, feed_index, sort_clr : sort-chain input tags and clear (ctrl -> datapath)
//   label_nn_vec        : labels held by sort stages K-1..0, stage 0 in the LSBs
interface knn_seq_ctrl_if #(
  parameter int unsigned K = 5
);
  import knn_pkg::*;

  logic                 start;
  logic [IDX_W-1:0]     n_train;
  logic                 busy;
  logic                 done;
  logic [LBL_W-1:0]     class_out;
  logic                 mem_rd_en;
  logic [IDX_W-1:0]     mem_addr;
  logic                 feed_valid;
  logic [IDX_W-1:0]     feed_index;
  logic                 sort_clr;
  logic [LBL_W*K-1:0]   label_nn_vec;

  modport master (
    output start, n_train, label_nn_vec,
    input  busy, done, class_out, mem_rd_en, mem_addr, feed_valid, feed_index, sort_clr
  );

  modport slave (
    input  start, n_train, label_nn_vec,
    output busy, done, class_out, mem_rd_en, mem_addr, feed_valid, feed_index, sort_clr
  );

endinterface

// File: rtl/knn_vote.sv
// Combinational majority vote over the K nearest-neighbour labels.
//   label_nn_vec : labels of stages K-1..0, stage 0 in the LSBs
//   vote_class   : label with the highest count; ties go to stage 0's label when it is
//                  among the tied, otherwise to the lowest tied label
//   max_cnt      : occurrence count of the winning label
module knn_vote
  import knn_pkg::*;
#(
  parameter int unsigned K = 5
) (
  input  logic [LBL_W*K-1:0] label_nn_vec,
  output logic [LBL_W-1:0]   vote_class,
  output logic [CNT_W-1:0]   max_cnt
);

  logic [CNT_W-1:0] cnt [NUM_LABEL];
  logic [LBL_W-1:0] lbl0;
  logic             found;

  assign lbl0 = label_nn_vec[LBL_W-1:0];

  always_comb begin
    for (int l = 0; l < NUM_LABEL; l++) begin
      cnt[l] = '0;
    end
    for (int s = 0; s < K; s++) begin
      cnt[label_nn_vec[s*LBL_W +: LBL_W]] = cnt[label_nn_vec[s*LBL_W +: LBL_W]] + 4'd1;
    end

    max_cnt = '0;
    for (int l = 0; l < NUM_LABEL; l++) begin
      if (cnt[l] > max_cnt) max_cnt = cnt[l];
    end

    vote_class = '0;
    found      = 1'b0;
    if (cnt[lbl0] == max_cnt) begin
      // Nearest neighbour's label wins any tie it takes part in.
      vote_class = lbl0;
      found      = 1'b1;
    end
    for (int l = 0; l < NUM_LABEL; l++) begin
      if (!found && cnt[l] == max_cnt) begin
        vote_class = l[LBL_W-1:0];
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/knn_seq_ctrl.sv
// kNN query sequencer: clears the K-stage insertion-sort chain, streams n_train sample
// addresses, tags the chain input with valid/index (delayed PIPE_LAT cycles), waits for the
// last sample to pass all stages, then votes the K labels and pulses done.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : knn_seq_ctrl_if slave modport (query handshake, memory and chain controls)
// The interface instance must be built with the same K as this module.
module knn_seq_ctrl
  import knn_pkg::*;
#(
  parameter int unsigned K        = 5,
  parameter int unsigned PIPE_LAT = 3
) (
  input logic          clk,
  input logic          rst_n,
  knn_seq_ctrl_if.slave bus
);

  localparam logic [4:0] LastDrain = 5'(PIPE_LAT + K - 1);

  state_t            state_q;
  logic [IDX_W-1:0]  ntr_q;
  logic              busy_q;
  logic              done_q;
  logic [LBL_W-1:0]  class_q;
  logic              rd_en_q;
  logic [IDX_W-1:0]  addr_q;
  logic              clr_q;
  logic [4:0]        drain_q;

  logic [PIPE_LAT-1:0] dl_valid_q;
  logic [IDX_W-1:0]    dl_index_q [PIPE_LAT];

  logic [LBL_W-1:0]  vote_class;
  logic [CNT_W-1:0]  vote_max;

  knn_vote #(
    .K(K)
  ) u_vote (
    .label_nn_vec (bus.label_nn_vec),
    .vote_class   (vote_class),
    .max_cnt      (vote_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ntr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      class_q <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      clr_q   <= 1'b0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            ntr_q   <= bus.n_train;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          clr_q <= 1'b0;
          if (ntr_q == '0) begin
            state_q <= VOTE;
          end else begin
            rd_en_q <= 1'b1;
            addr_q  <= '0;
            state_q <= FEED;
          end
        end
        FEED: begin
          if (addr_q == ntr_q - 8'd1) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            drain_q <= '0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 8'd1;
          end
        end
        DRAIN: begin
          // Last sample needs PIPE_LAT cycles to reach the chain and K more to settle.
          if (drain_q == LastDrain) begin
            state_q <= VOTE;
          end else begin
            drain_q <= drain_q + 5'd1;
          end
        end
        VOTE: begin
          class_q <= (ntr_q == '0) ? '0 : vote_class;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Models the memory + distance latency so valid/index line up with the distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_index_q[i] <= '0;
      end
    end else begin
      dl_valid_q[0] <= rd_en_q;
      dl_index_q[0] <= addr_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_index_q[i] <= dl_index_q[i-1];
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.class_out  = class_q;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.sort_clr   = clr_q;
  assign bus.feed_valid = dl_valid_q[PIPE_LAT-1];
  assign bus.feed_index = dl_index_q[PIPE_LAT-1];

  // Any K >= 1 labels give the winner at least one vote.
  a_vote_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    state_q == VOTE |-> vote_max != '0);

endmodule
